// File: rtl/prog_loader.sv
// Streams a length-prefixed, checksummed program into instruction memory while holding the CPU.
// One byte per cycle when byte_valid is high, plus one WRITE cycle per word; upstream is stalled whenever byte_ready is low.
module prog_loader #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_wdata,
   output logic              cpu_hold,
   output logic              done,
   output logic              error
);

   // One spare bit so a full-memory count (2^ADDR_W) is representable.
   localparam int CW = 17;
   localparam logic [CW-1:0] CAP = CW'(1) << ADDR_W;

   typedef enum logic [3:0] {
      S_IDLE, S_CNT_HI, S_CNT_LO, S_DAT_HI, S_DAT_LO,
      S_WRITE, S_CK_HI, S_CK_LO, S_DONE, S_ERR
   } state_t;

   state_t              state_q, state_d;
   logic [7:0]          hi_q, hi_d;
   logic [15:0]         cnt_q, cnt_d;
   logic [CW-1:0]       idx_q, idx_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [15:0]         wdata_q, wdata_d;
   logic [15:0]         sum_q, sum_d;
   logic                done_q, done_d;
   logic                error_q, error_d;
   logic                xfer;
   logic [15:0]         word;

   assign byte_ready = (state_q == S_CNT_HI) || (state_q == S_CNT_LO) ||
                       (state_q == S_DAT_HI) || (state_q == S_DAT_LO) ||
                       (state_q == S_CK_HI)  || (state_q == S_CK_LO);
   assign xfer       = byte_valid & byte_ready;
   assign word       = {hi_q, byte_data};
   assign mem_we     = (state_q == S_WRITE);
   assign mem_addr   = addr_q;
   assign mem_wdata  = wdata_q;
   assign cpu_hold   = !((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR));
   assign done       = done_q;
   assign error      = error_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         hi_q    <= '0;
         cnt_q   <= '0;
         idx_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         sum_q   <= '0;
         done_q  <= 1'b0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         hi_q    <= hi_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         sum_q   <= sum_d;
         done_q  <= done_d;
         error_q <= error_d;
      end
   end

   always_comb begin
      state_d = state_q;
      hi_d    = hi_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      sum_d   = sum_q;
      done_d  = done_q;
      error_d = error_q;

      if (abort) begin
         state_d = S_IDLE;
         done_d  = 1'b0;
         error_d = 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
               if (start) begin
                  state_d = S_CNT_HI;
                  done_d  = 1'b0;
                  error_d = 1'b0;
                  idx_d   = '0;
                  sum_d   = '0;
               end
            end
            S_CNT_HI: if (xfer) begin
               hi_d    = byte_data;
               state_d = S_CNT_LO;
            end
            S_CNT_LO: if (xfer) begin
               cnt_d = word;
               if ({1'b0, word} > CAP) begin
                  state_d = S_ERR;
                  error_d = 1'b1;
               end else if (word == 16'd0) begin
                  state_d = S_CK_HI;
               end else begin
                  state_d = S_DAT_HI;
               end
            end
            S_DAT_HI: if (xfer) begin
               hi_d    = byte_data;
               state_d = S_DAT_LO;
            end
            S_DAT_LO: if (xfer) begin
               wdata_d = word;
               addr_d  = idx_q[ADDR_W-1:0];
               sum_d   = sum_q + word;
               state_d = S_WRITE;
            end
            S_WRITE: begin
               idx_d   = idx_q + CW'(1);
               state_d = (idx_d < {1'b0, cnt_q}) ? S_DAT_HI : S_CK_HI;
            end
            S_CK_HI: if (xfer) begin
               hi_d    = byte_data;
               state_d = S_CK_LO;
            end
            S_CK_LO: if (xfer) begin
               if (word == sum_q) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_ERR;
                  error_d = 1'b1;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: table of directed streams, random streams against a stream-level model, and hand sequences for abort/reset corners.
module tb_prog_loader;
   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          rst, start, abort, byte_valid;
   logic [7:0]    byte_data;
   logic          byte_ready, mem_we, cpu_hold, done, error;
   logic [AW-1:0] mem_addr;
   logic [15:0]   mem_wdata;

   always #5 clk = ~clk;

   prog_loader #(.ADDR_W(AW)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .cpu_hold(cpu_hold), .done(done), .error(error)
   );

   typedef logic [7:0] bq_t[$];
   typedef struct {
      logic [63:0] bytes;
      int          n;
      bit          exp_done;
      bit          exp_err;
      int          exp_nw;
   } vec_t;

   logic [AW+15:0] act_w[$];
   logic [AW+15:0] exp_w[$];
   bit             exp_done, exp_err;
   int             checks = 0;
   int             failures = 0;

   // Every cycle with mem_we high is one write; a strobe held two cycles shows up as a duplicate.
   always @(negedge clk) if (mem_we === 1'b1) act_w.push_back({mem_addr, mem_wdata});

   initial begin
      #1_000_000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   // Stream-level reference: parse count, words and checksum straight from the byte list.
   task automatic model(input bq_t s);
      int          cnt;
      logic [15:0] sum, w, ck;
      exp_w.delete();
      exp_done = 0;
      exp_err  = 0;
      cnt = {s[0], s[1]};
      if (cnt > (1 << AW)) begin
         exp_err = 1;
         return;
      end
      sum = 16'd0;
      for (int i = 0; i < cnt; i++) begin
         w = {s[2 + 2*i], s[3 + 2*i]};
         exp_w.push_back({AW'(i), w});
         sum = sum + w;
      end
      ck = {s[2 + 2*cnt], s[3 + 2*cnt]};
      exp_done = (ck == sum);
      exp_err  = !exp_done;
   endtask

   task automatic start_pulse();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, output bit ok);
      int t = 0;
      ok = 0;
      byte_valid = 1'b1;
      byte_data  = b;
      while (!byte_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (byte_ready) begin
         ok = 1;
         @(negedge clk);
      end
      byte_valid = 1'b0;
   endtask

   task automatic send_seq(input bq_t s, input int gap, output int acc);
      bit ok;
      acc = 0;
      foreach (s[k]) begin
         send_byte(s[k], ok);
         if (!ok) break;
         acc++;
         repeat (gap) @(negedge clk);
      end
   endtask

   task automatic wait_end();
      int t = 0;
      while (!(done || error) && t < 20) begin
         @(negedge clk);
         t++;
      end
   endtask

   task automatic run_session(input bq_t s, input int gap, input string tag);
      int acc, bad;
      act_w.delete();
      start_pulse();
      send_seq(s, gap, acc);
      wait_end();
      model(s);
      chk({tag, "_accepted"}, 64'(acc), 64'(s.size()));
      chk({tag, "_done"}, 64'(done), 64'(exp_done));
      chk({tag, "_error"}, 64'(error), 64'(exp_err));
      chk({tag, "_cpu_hold"}, 64'(cpu_hold), 64'd0);
      chk({tag, "_byte_ready"}, 64'(byte_ready), 64'd0);
      chk({tag, "_nwrites"}, 64'(act_w.size()), 64'(exp_w.size()));
      bad = 0;
      for (int i = 0; i < act_w.size() && i < exp_w.size(); i++)
         if (act_w[i] !== exp_w[i]) bad++;
      chk({tag, "_write_contents"}, 64'(bad), 64'd0);
   endtask

   vec_t tbl[5];
   bq_t  s;
   int   acc;
   bit   ok;

   initial begin
      tbl[0] = '{64'h0002_1234_ABCD_BE01, 8, 1'b1, 1'b0, 2};
      tbl[1] = '{64'h0000_0000_0000_0000, 4, 1'b1, 1'b0, 0};
      tbl[2] = '{64'h0401_0000_0000_0000, 2, 1'b0, 1'b1, 0};
      tbl[3] = '{64'h0001_0005_0006_0000, 6, 1'b0, 1'b1, 1};
      tbl[4] = '{64'h0002_FFFF_0002_0001, 8, 1'b1, 1'b0, 2};

      rst = 1'b1; start = 1'b0; abort = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
      #1;
      chk("reset_outputs", {62'd0, byte_ready, mem_we}, 64'd0);
      chk("reset_status", {61'd0, cpu_hold, done, error}, 64'd0);
      chk("reset_mem_addr", 64'(mem_addr), 64'd0);
      chk("reset_mem_wdata", 64'(mem_wdata), 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 5; i++) begin
         s.delete();
         for (int k = 0; k < tbl[i].n; k++) s.push_back(tbl[i].bytes[63 - 8*k -: 8]);
         run_session(s, 0, $sformatf("vec%0d", i));
         chk($sformatf("vec%0d_tbl_done", i), 64'(done), 64'(tbl[i].exp_done));
         chk($sformatf("vec%0d_tbl_error", i), 64'(error), 64'(tbl[i].exp_err));
         chk($sformatf("vec%0d_tbl_nwrites", i), 64'(act_w.size()), 64'(tbl[i].exp_nw));
      end

      for (int r = 0; r < 30; r++) begin
         int cnt;
         logic [15:0] sum, w;
         s.delete();
         cnt = ($urandom_range(0, 9) == 0) ? 1025 + $urandom_range(0, 3000) : $urandom_range(0, 6);
         s.push_back(8'(cnt >> 8));
         s.push_back(8'(cnt));
         if (cnt <= (1 << AW)) begin
            sum = 16'd0;
            for (int i = 0; i < cnt; i++) begin
               w = 16'($urandom);
               sum = sum + w;
               s.push_back(w[15:8]);
               s.push_back(w[7:0]);
            end
            if ($urandom_range(0, 3) == 0) sum = 16'($urandom);
            s.push_back(sum[15:8]);
            s.push_back(sum[7:0]);
         end
         run_session(s, $urandom_range(0, 3), $sformatf("rnd%0d", r));
      end

      // Abort and start together while in DONE: abort must win.
      s = '{8'h00, 8'h00, 8'h00, 8'h00};
      run_session(s, 0, "pre_abort");
      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      chk("abort_start_cpu_hold", 64'(cpu_hold), 64'd0);
      chk("abort_start_done", 64'(done), 64'd0);
      chk("abort_start_ready", 64'(byte_ready), 64'd0);

      act_w.delete();
      start_pulse();
      send_seq('{8'h00, 8'h01}, 0, acc);
      start_pulse();
      send_seq('{8'h00, 8'h05, 8'h00, 8'h05}, 0, acc);
      wait_end();
      chk("start_ignored_done", 64'(done), 64'd1);
      chk("start_ignored_nwrites", 64'(act_w.size()), 64'd1);
      chk("start_ignored_word", 64'(act_w[0]), 64'({AW'(0), 16'h0005}));

      act_w.delete();
      start_pulse();
      send_seq('{8'h00, 8'h02, 8'h12, 8'h34}, 3, acc);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      repeat (3) @(negedge clk);
      chk("abort_gap_nwrites", 64'(act_w.size()), 64'd1);
      chk("abort_gap_status", {60'd0, cpu_hold, byte_ready, done, error}, 64'd0);

      act_w.delete();
      start_pulse();
      send_seq('{8'h00, 8'h02, 8'h12, 8'h34}, 0, acc);
      chk("abort_write_we_now", 64'(mem_we), 64'd1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_write_idle", {62'd0, cpu_hold, mem_we}, 64'd0);
      repeat (3) @(negedge clk);
      chk("abort_write_nwrites", 64'(act_w.size()), 64'd1);
      chk("abort_write_word", 64'(act_w[0]), 64'({AW'(0), 16'h1234}));

      // Largest legal image fills every address.
      s.delete();
      begin
         logic [15:0] sum, w;
         sum = 16'd0;
         s.push_back(8'h04);
         s.push_back(8'h00);
         for (int i = 0; i < (1 << AW); i++) begin
            w = 16'($urandom);
            sum = sum + w;
            s.push_back(w[15:8]);
            s.push_back(w[7:0]);
         end
         s.push_back(sum[15:8]);
         s.push_back(sum[7:0]);
      end
      run_session(s, 0, "full");
      chk("full_last_addr", 64'(act_w[$][AW+15:16]), 64'((1 << AW) - 1));

      // Asynchronous reset between edges while waiting in DAT_LO.
      act_w.delete();
      start_pulse();
      send_seq('{8'h00, 8'h02, 8'h12}, 0, acc);
      #2 rst = 1'b1;
      #1;
      chk("rst_async_ctrl", {59'd0, byte_ready, mem_we, cpu_hold, done, error}, 64'd0);
      chk("rst_async_mem_addr", 64'(mem_addr), 64'd0);
      chk("rst_async_mem_wdata", 64'(mem_wdata), 64'd0);
      #1 rst = 1'b0;
      @(negedge clk);
      send_byte(8'h34, ok);
      chk("rst_byte_refused", 64'(ok), 64'd0);
      chk("rst_no_writes", 64'(act_w.size()), 64'd0);
      run_session('{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBE, 8'h01}, 0, "post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
